// File: rtl/conv_out_serializer.sv
// Compacts up to P lane pixels per clock into a FWFT pixel FIFO and replays them one per clock with SOF/EOL/EOF tags.
// Latency: write at edge N is visible at cycle N+1. No input backpressure: bursts that do not fit are dropped whole and flagged.
module conv_out_serializer #(
   parameter int P     = 4,
   parameter int PIXW  = 8,
   parameter int DEPTH = 16,
   parameter int OUT_W = 254,
   parameter int OUT_H = 254
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [P-1:0]             in_valid_vec,
   input  logic [P*PIXW-1:0]        in_pix_vec,
   input  logic                     clr_ovf,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [PIXW-1:0]          out_pix,
   output logic                     out_sof,
   output logic                     out_eol,
   output logic                     out_eof,
   output logic                     almost_full,
   output logic                     overflow,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int XW = (OUT_W > 1) ? $clog2(OUT_W) : 1;
   localparam int YW = (OUT_H > 1) ? $clog2(OUT_H) : 1;
   localparam logic [XW-1:0] COL_LAST = XW'(OUT_W - 1);
   localparam logic [YW-1:0] ROW_LAST = YW'(OUT_H - 1);
   localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
   localparam logic [CW-1:0] P_C      = CW'(P);

   logic [PIXW-1:0] mem [DEPTH];
   logic [AW-1:0]   wp;
   logic [AW-1:0]   rp;
   logic [CW-1:0]   cnt;
   logic [XW-1:0]   col;
   logic [YW-1:0]   row;
   logic            ovf_q;

   logic [AW-1:0]   lane_off [P];
   logic [CW-1:0]   n;
   logic [CW-1:0]   free;
   logic            drop;
   logic            pop;

   // Each valid lane's slot offset is the number of valid lanes below it.
   always_comb begin
      n        = '0;
      lane_off = '{default: '0};
      for (int i = 0; i < P; i++) begin
         lane_off[i] = n[AW-1:0];
         n           = n + CW'(in_valid_vec[i]);
      end
   end

   // Admission looks at the pre-pop occupancy, so a full FIFO drops even while popping.
   assign free = DEPTH_C - cnt;
   assign drop = (n > free);
   assign pop  = out_valid & out_ready;

   always_ff @(posedge clk) begin
      if (!drop) begin
         for (int i = 0; i < P; i++) begin
            if (in_valid_vec[i]) begin
               mem[wp + lane_off[i]] <= in_pix_vec[i*PIXW +: PIXW];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wp    <= '0;
         rp    <= '0;
         cnt   <= '0;
         col   <= '0;
         row   <= '0;
         ovf_q <= 1'b0;
      end else begin
         if (!drop) begin
            wp <= wp + n[AW-1:0];
         end
         if (pop) begin
            rp <= rp + 1'b1;
         end
         cnt <= cnt + (drop ? '0 : n) - CW'(pop);
         if (drop) begin
            ovf_q <= 1'b1;
         end else if (clr_ovf) begin
            ovf_q <= 1'b0;
         end
         if (pop) begin
            if (col == COL_LAST) begin
               col <= '0;
               row <= (row == ROW_LAST) ? '0 : row + 1'b1;
            end else begin
               col <= col + 1'b1;
            end
         end
      end
   end

   assign out_valid   = (cnt != '0);
   assign out_pix     = mem[rp];
   assign level       = cnt;
   assign almost_full = (free < P_C);
   assign overflow    = ovf_q;
   assign out_sof     = (row == '0) && (col == '0);
   assign out_eol     = (col == COL_LAST);
   assign out_eof     = out_eol && (row == ROW_LAST);

endmodule

// File: tb/tb_conv_out_serializer.sv
// Bench for conv_out_serializer: directed scenarios plus random traffic against a queue-based reference model.
module tb_conv_out_serializer;

   localparam int P     = 4;
   localparam int PIXW  = 8;
   localparam int DEPTH = 16;
   localparam int OUT_W = 4;
   localparam int OUT_H = 2;

   logic                   clk = 1'b0;
   logic                   rst_n = 1'b0;
   logic [P-1:0]           in_valid_vec = '0;
   logic [P*PIXW-1:0]      in_pix_vec = '0;
   logic                   clr_ovf = 1'b0;
   logic                   out_valid;
   logic                   out_ready = 1'b0;
   logic [PIXW-1:0]        out_pix;
   logic                   out_sof, out_eol, out_eof;
   logic                   almost_full, overflow;
   logic [$clog2(DEPTH):0] level;

   conv_out_serializer #(.P(P), .PIXW(PIXW), .DEPTH(DEPTH), .OUT_W(OUT_W), .OUT_H(OUT_H)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid_vec(in_valid_vec), .in_pix_vec(in_pix_vec),
      .clr_ovf(clr_ovf), .out_valid(out_valid), .out_ready(out_ready), .out_pix(out_pix),
      .out_sof(out_sof), .out_eol(out_eol), .out_eof(out_eof), .almost_full(almost_full),
      .overflow(overflow), .level(level)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: pixel queue, sticky flag and count of pops within the frame.
   logic [PIXW-1:0] q[$];
   logic            m_ovf = 1'b0;
   int              m_pos = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_model();
      int sz;
      sz = q.size();
      chk("valid", 32'(out_valid), 32'(sz != 0));
      chk("level", 32'(level), 32'(sz));
      chk("almost_full", 32'(almost_full), 32'((DEPTH - sz) < P));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      if (sz != 0) begin
         chk("pix", 32'(out_pix), 32'(q[0]));
         chk("sof", 32'(out_sof), 32'(m_pos == 0));
         chk("eol", 32'(out_eol), 32'((m_pos % OUT_W) == OUT_W - 1));
         chk("eof", 32'(out_eof), 32'(m_pos == OUT_W * OUT_H - 1));
      end
   endtask

   // Called at a falling edge: drive, advance the model by one clock, compare at the next falling edge.
   task automatic step(input logic [P-1:0] v, input logic [P*PIXW-1:0] px,
                       input logic rdy, input logic clr);
      int sz;
      int nv;
      in_valid_vec = v;
      in_pix_vec   = px;
      out_ready    = rdy;
      clr_ovf      = clr;
      sz = q.size();
      nv = $countones(v);
      if (nv > DEPTH - sz) begin
         m_ovf = 1'b1;
      end else begin
         for (int i = 0; i < P; i++)
            if (v[i]) q.push_back(px[i*PIXW +: PIXW]);
         if (clr) m_ovf = 1'b0;
      end
      if (sz != 0 && rdy) begin
         void'(q.pop_front());
         m_pos = (m_pos + 1) % (OUT_W * OUT_H);
      end
      @(posedge clk);
      @(negedge clk);
      check_model();
   endtask

   task automatic do_reset();
      in_valid_vec = '0;
      out_ready    = 1'b0;
      clr_ovf      = 1'b0;
      rst_n        = 1'b0;
      #1;
      chk("rst_level", 32'(level), 32'd0);
      chk("rst_valid", 32'(out_valid), 32'd0);
      q.delete();
      m_ovf = 1'b0;
      m_pos = 0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      logic [P*PIXW-1:0] px;
      repeat (3) @(negedge clk);
      chk("init_valid", 32'(out_valid), 32'd0);
      chk("init_level", 32'(level), 32'd0);
      chk("init_ovf", 32'(overflow), 32'd0);
      chk("init_af", 32'(almost_full), 32'd0);
      chk("init_sof", 32'(out_sof), 32'd1);
      rst_n = 1'b1;
      repeat (10) step('0, '0, 1'b0, 1'b0);
      chk("idle_level", 32'(level), 32'd0);

      // Compaction: lanes 1 and 3 only.
      step(4'b1010, 32'h44332211, 1'b1, 1'b0);
      chk("cmp_level", 32'(level), 32'd2);
      chk("cmp_pix0", 32'(out_pix), 32'h22);
      step('0, '0, 1'b1, 1'b0);
      chk("cmp_pix1", 32'(out_pix), 32'h44);
      step('0, '0, 1'b1, 1'b0);
      chk("cmp_empty", 32'(out_valid), 32'd0);

      // Burst into a stalled sink, then overflow.
      for (int b = 0; b < 4; b++) step(4'b1111, 32'($urandom), 1'b0, 1'b0);
      chk("burst_level", 32'(level), 32'd16);
      chk("burst_af", 32'(almost_full), 32'd1);
      chk("burst_ovf", 32'(overflow), 32'd0);
      step(4'b1111, 32'($urandom), 1'b0, 1'b0);
      chk("ovf_set", 32'(overflow), 32'd1);
      chk("ovf_level", 32'(level), 32'd16);
      // Full with a pop and a single-lane write: write still dropped.
      step(4'b0001, 32'($urandom), 1'b1, 1'b0);
      chk("fullpop_level", 32'(level), 32'd15);
      chk("fullpop_ovf", 32'(overflow), 32'd1);
      step('0, '0, 1'b0, 1'b1);
      chk("clr_ovf", 32'(overflow), 32'd0);
      repeat (15) step('0, '0, 1'b1, 1'b0);
      chk("drain_empty", 32'(out_valid), 32'd0);

      // Framing over a fresh frame of 4x2 plus one more pixel.
      do_reset();
      step(4'b1111, 32'h03020100, 1'b0, 1'b0);
      step(4'b1111, 32'h07060504, 1'b0, 1'b0);
      step(4'b0001, 32'h00000008, 1'b0, 1'b0);
      for (int k = 0; k < 9; k++) begin
         chk("frm_valid", 32'(out_valid), 32'd1);
         chk("frm_pix", 32'(out_pix), 32'(k));
         chk("frm_sof", 32'(out_sof), 32'(k == 0 || k == 8));
         chk("frm_eol", 32'(out_eol), 32'(k == 3 || k == 7));
         chk("frm_eof", 32'(out_eof), 32'(k == 7));
         step('0, '0, 1'b1, 1'b0);
      end

      // Mid-frame reset with data still buffered.
      step(4'b1111, 32'($urandom), 1'b0, 1'b0);
      step(4'b1111, 32'($urandom), 1'b0, 1'b0);
      repeat (5) step('0, '0, 1'b1, 1'b0);
      chk("mr_level_pre", 32'(level), 32'd3);
      do_reset();
      step(4'b0100, 32'h00A50000, 1'b1, 1'b0);
      chk("mr_pix", 32'(out_pix), 32'hA5);
      chk("mr_sof", 32'(out_sof), 32'd1);
      step('0, '0, 1'b1, 1'b0);

      // Random traffic, including occasional dense bursts and clears.
      for (int c = 0; c < 600; c++) begin
         logic [P-1:0] v;
         v  = ($urandom_range(0, 3) == 0) ? P'($urandom) : '0;
         px = P*PIXW'($urandom);
         step(v, px, ($urandom_range(0, 9) < 7), ($urandom_range(0, 15) == 0));
      end
      repeat (DEPTH + 2) step('0, '0, 1'b1, 1'b0);
      chk("final_empty", 32'(out_valid), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
